// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared definitions for the HI/LO divide controller
// Holds the 2-bit FSM state encoding and the default abort limit so the
// controller, its timer and any divider-side logic agree on them.
package hilo_pkg;

  // Default cycles allowed from div_start to divider completion.
  localparam int TIMEOUT_DEFAULT = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ARM   = 2'd2,
    ST_WAIT  = 2'd3
  } hilo_state_t;

  // Counter width able to hold values 0..limit.
  function automatic int timer_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/hilo_timer.sv
// rtl/hilo_timer.sv - divide timeout counter
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous clear (wins over enable)
//   enable    : count this cycle
//   count     : cycles counted since the last clear (saturates at LIMIT)
//   expired   : this enabled cycle is the LIMIT-th one since clear
module hilo_timer
  import hilo_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT,
  parameter int W     = timer_width(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

  // Flag the cycle whose increment brings the count to LIMIT, so the abort
  // lands exactly LIMIT cycles after the clearing cycle.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register file and multi-cycle divider sequencer
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   div_req, op_a, op_b         : divide request with signed dividend/divisor
//   mfhi, mflo, mthi, mtlo      : HI/LO move requests; wr_data feeds mthi/mtlo
//   rd_data                     : HI on mfhi, LO on mflo, else 0
//   stall                       : pipeline must hold the current instruction
//   div_start, div_dividend,
//   div_divisor, div_rst        : drive to the external divider
//   div_end, div_hi, div_lo     : divider completion and results
//   busy, dz_exc, to_exc        : divide in flight, divide-by-zero, timeout
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mfhi,
  input  logic        mflo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_rst,
  input  logic        div_end,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        busy,
  output logic        dz_exc,
  output logic        to_exc
);

  localparam int TW = timer_width(TIMEOUT);

  hilo_state_t   state, state_nx;
  logic [31:0]   hi, lo;
  logic          idle, accept, zero_div, done, abort;
  logic          tmr_clear, tmr_en, tmr_expired;
  logic [TW-1:0] tmr_count;
  logic          unused_count;

  assign idle     = (state == ST_IDLE);
  assign accept   = idle && div_req && (op_b != '0);
  assign zero_div = idle && div_req && (op_b == '0);
  assign done     = (state == ST_WAIT) && div_end;
  assign tmr_clear = (state == ST_ISSUE);
  assign tmr_en    = (state == ST_ARM) || (state == ST_WAIT);
  // A completion seen on the same cycle as expiry is still honoured.
  assign abort     = tmr_en && tmr_expired && !done;

  hilo_timer #(.LIMIT(TIMEOUT), .W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  assign unused_count = ^tmr_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_ARM;
      // div_end must drop first so a stale completion from a previous
      // divide is never mistaken for this one.
      ST_ARM:   if (abort) state_nx = ST_IDLE;
                else if (!div_end) state_nx = ST_WAIT;
      ST_WAIT:  if (done || abort) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      dz_exc       <= 1'b0;
    end else begin
      dz_exc <= zero_div;
      if (accept) begin
        div_dividend <= op_a;
        div_divisor  <= op_b;
      end
    end
  end

  // A divide request in IDLE (even a divide-by-zero) suppresses mthi/mtlo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= div_hi;
      lo <= div_lo;
    end else if (idle && !div_req) begin
      if (mthi) hi <= wr_data;
      if (mtlo) lo <= wr_data;
    end
  end

  assign busy      = !idle;
  assign div_start = (state == ST_ISSUE);
  assign to_exc    = abort;
  assign div_rst   = rst || abort;
  assign stall     = busy && (div_req || mfhi || mflo || mthi || mtlo);
  assign rd_data   = mfhi ? hi : (mflo ? lo : 32'd0);

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - self-checking bench for hilo_ctrl with a divider model
module tb_hilo_ctrl;

  localparam int TMO     = 40;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req;
  logic [31:0] op_a, op_b;
  logic        mfhi, mflo, mthi, mtlo;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        stall;
  logic        div_start;
  logic [31:0] div_dividend, div_divisor;
  logic        div_rst;
  logic        div_end;
  logic [31:0] div_hi, div_lo;
  logic        busy, dz_exc, to_exc;

  always #5 clk = ~clk;

  hilo_ctrl #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_req      (div_req),
    .op_a         (op_a),
    .op_b         (op_b),
    .mfhi         (mfhi),
    .mflo         (mflo),
    .mthi         (mthi),
    .mtlo         (mtlo),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .stall        (stall),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_rst      (div_rst),
    .div_end      (div_end),
    .div_hi       (div_hi),
    .div_lo       (div_lo),
    .busy         (busy),
    .dz_exc       (dz_exc),
    .to_exc       (to_exc)
  );

  // Divider model: div_end drops the cycle after div_start and rises with
  // results DIV_LAT cycles later, unless hang is set.
  logic        hang = 1'b0;
  logic        inj  = 1'b0;
  logic        dend_r = 1'b1;
  int          dcnt = 0;
  logic [31:0] q_n = '0, r_n = '0;

  initial begin
    div_hi = '0;
    div_lo = '0;
  end

  assign div_end = dend_r && !inj;

  always @(posedge clk) begin
    if (div_rst) begin
      dend_r <= 1'b1;
      dcnt   <= 0;
    end else if (div_start) begin
      dend_r <= 1'b0;
      dcnt   <= DIV_LAT;
      q_n    <= $signed(div_dividend) / $signed(div_divisor);
      r_n    <= $signed(div_dividend) % $signed(div_divisor);
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !hang) begin
        dend_r <= 1'b1;
        div_lo <= q_n;
        div_hi <= r_n;
      end
    end
  end

  // Architectural model of HI/LO; m_pending marks spans where a divide or
  // reset makes the registers transiently unknown to the model.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_pending = 1'b1;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int n_start = 0, n_dz = 0, n_to = 0, n_drst = 0;
  int start_cyc = 0, to_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (div_start) begin n_start++; start_cyc = cyc; end
    if (dz_exc) n_dz++;
    if (to_exc) begin n_to++; to_cyc = cyc; end
    if (div_rst && !rst) n_drst++;
    if (!m_pending && !rst) begin
      chk("rd_data_model", rd_data, mfhi ? m_hi : (mflo ? m_lo : 32'd0));
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("no_div_start", {31'd0, div_start}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_hl(input bit w_hi, input bit w_lo, input logic [31:0] d);
    mthi = w_hi; mtlo = w_lo; wr_data = d;
    tick();
    if (w_hi) m_hi = d;
    if (w_lo) m_lo = d;
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  task automatic read_reg(input bit sel_hi, input logic [31:0] exp, input string nm);
    mfhi = sel_hi; mflo = !sel_hi;
    @(negedge clk);
    chk(nm, rd_data, exp);
    tick();
    mfhi = 1'b0; mflo = 1'b0;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input bit ok, input bit with_mthi);
    int lat;
    op_a = a; op_b = b; div_req = 1'b1; mthi = with_mthi; wr_data = 32'hDEAD_BEEF;
    m_pending = 1'b1;
    @(negedge clk);
    chk("stall_on_accept", {31'd0, stall}, 32'd0);
    tick();
    div_req = 1'b0; mthi = 1'b0;
    op_a = $urandom; op_b = $urandom;
    for (int n = 0; n < 300 && busy; n++) begin
      @(negedge clk);
      chk("dividend_hold", div_dividend, a);
      chk("divisor_hold", div_divisor, b);
      tick();
    end
    chk("div_done", {31'd0, busy}, 32'd0);
    lat = cyc - start_cyc;
    if (ok) begin
      chk("div_latency_34_35", {31'd0, (lat >= 34 && lat <= 35)}, 32'd1);
      m_lo = $signed(a) / $signed(b);
      m_hi = $signed(a) % $signed(b);
    end
    m_pending = 1'b0;
  endtask

  initial begin : stim
    int s0, d0, t0, r0, stall_n;
    rst = 1'b1; div_req = 1'b0; op_a = '0; op_b = '0;
    mfhi = 1'b1; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rd_hi", rd_data, 32'd0);
    chk("rst_div_rst", {31'd0, div_rst}, 32'd1);
    chk("rst_div_start", {31'd0, div_start}, 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    chk("rst_exc", {30'd0, dz_exc, to_exc}, 32'd0);
    mfhi = 1'b0;
    rst = 1'b0; m_pending = 1'b0;
    tick();
    chk("div_rst_released", {31'd0, div_rst}, 32'd0);

    // Moves, including simultaneous write and read-before-write.
    write_hl(1'b1, 1'b1, 32'h55);
    read_reg(1'b1, 32'h55, "mthi_both");
    read_reg(1'b0, 32'h55, "mtlo_both");
    mfhi = 1'b1; mthi = 1'b1; wr_data = 32'hAAAA;
    @(negedge clk);
    chk("read_before_write_hi", rd_data, 32'h55);
    tick();
    m_hi = 32'hAAAA; mfhi = 1'b0; mthi = 1'b0;
    read_reg(1'b1, 32'hAAAA, "hi_after_rbw");

    // Divide by zero.
    write_hl(1'b1, 1'b1, 32'h55);
    s0 = n_start; d0 = n_dz;
    op_a = 32'd9; op_b = 32'd0; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    repeat (3) tick();
    chk("dz_one_pulse", n_dz - d0, 32'd1);
    chk("dz_no_start", n_start - s0, 32'd0);
    read_reg(1'b1, 32'h55, "dz_hi_kept");
    read_reg(1'b0, 32'h55, "dz_lo_kept");

    // 100 / 7
    s0 = n_start; d0 = n_dz; t0 = n_to;
    run_div(32'd100, 32'd7, 1'b1, 1'b0);
    chk("div_one_start", n_start - s0, 32'd1);
    chk("div_no_exc", (n_dz - d0) + (n_to - t0), 32'd0);
    read_reg(1'b0, 32'd14, "lo_100_7");
    read_reg(1'b1, 32'd2, "hi_100_7");

    // -7 / 2
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    read_reg(1'b0, 32'hFFFF_FFFD, "lo_m7_2");
    read_reg(1'b1, 32'hFFFF_FFFF, "hi_m7_2");

    // mflo right behind a divide stalls until the result lands.
    op_a = 32'd100; op_b = 32'd7; div_req = 1'b1; m_pending = 1'b1;
    tick();
    div_req = 1'b0; mflo = 1'b1;
    stall_n = 0;
    @(negedge clk);
    while (stall && stall_n < 300) begin
      stall_n++;
      @(negedge clk);
    end
    chk("mflo_stall_long", {31'd0, (stall_n >= 30)}, 32'd1);
    chk("mflo_after_stall", rd_data, 32'd14);
    chk("mflo_busy_low", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    mflo = 1'b0; m_lo = 32'd14; m_hi = 32'd2; m_pending = 1'b0;

    // Divide wins over a simultaneous mthi.
    run_div(32'd50, 32'd5, 1'b1, 1'b1);
    read_reg(1'b1, 32'd0, "div_over_mthi_hi");
    read_reg(1'b0, 32'd10, "div_over_mthi_lo");

    // Divider never completes: timeout abort.
    hang = 1'b1;
    t0 = n_to; r0 = n_drst;
    run_div(32'd9, 32'd3, 1'b0, 1'b0);
    chk("to_one_pulse", n_to - t0, 32'd1);
    chk("div_rst_one_pulse", n_drst - r0, 32'd1);
    chk("to_delay", to_cyc - start_cyc, TMO);
    read_reg(1'b1, 32'd0, "to_hi_kept");
    read_reg(1'b0, 32'd10, "to_lo_kept");
    hang = 1'b0;
    run_div(32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b0);
    read_reg(1'b0, 32'hFFFF_FEB3, "lo_1000_m3");
    read_reg(1'b1, 32'd1, "hi_1000_m3");

    // Reset in the middle of WAIT.
    op_a = 32'd100; op_b = 32'd7; div_req = 1'b1; m_pending = 1'b1;
    tick();
    div_req = 1'b0;
    repeat (10) tick();
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1; mfhi = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_div_rst", {31'd0, div_rst}, 32'd1);
    chk("mid_rst_hi", rd_data, 32'd0);
    mfhi = 1'b0;
    m_hi = '0; m_lo = '0;
    tick();
    rst = 1'b0; m_pending = 1'b0;
    inj = 1'b1;
    repeat (2) tick();
    inj = 1'b0;
    repeat (2) tick();
    read_reg(1'b1, 32'd0, "post_rst_hi");
    read_reg(1'b0, 32'd0, "post_rst_lo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, giving the max cycles from div_start to divider completion before abort.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port div_req  input  1  pipeline requests DIV; operands valid same cycle.
REQ-005 SHALL have port op_a, op_b  input  32 each  signed dividend, divisor.
REQ-006 SHALL have port mfhi, mflo, mthi, mtlo  input  1 each  HI/LO move requests.
REQ-007 SHALL have port wr_data  input  32  data for mthi/mtlo.
REQ-008 SHALL have port rd_data  output  32  HI when mfhi, LO when mflo, else 0; combinational from registers.
REQ-009 SHALL have port stall  output  1  pipeline must hold current instruction.
REQ-010 SHALL have ports div_start (output 1), div_dividend (output 32), div_divisor (output 32), div_rst (output 1): divider drive.
REQ-011 SHALL have ports div_end (input 1), div_hi (input 32), div_lo (input 32): divider results; divider's zero flag is not used.
REQ-012 SHALL have ports busy, dz_exc, to_exc  output  1 each  divide in flight, divide-by-zero pulse, timeout pulse.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, ARM, WAIT; busy=1 in any state except IDLE.
REQ-014 In IDLE with div_req and op_b!=0 SHALL latch op_a/op_b into div_dividend/div_divisor and go ISSUE.
REQ-015 In IDLE with div_req and op_b==0 SHALL pulse dz_exc one cycle, leave HI/LO unchanged, stay IDLE, and never start the divider.
REQ-016 ISSUE SHALL assert div_start exactly one cycle, clear the timeout counter, and go ARM.
REQ-017 ARM SHALL wait for div_end==0 (divider accepted; clears stale completion), then go WAIT.
REQ-018 WAIT SHALL, on div_end==1, write div_hi to HI and div_lo to LO and go IDLE; nominal latency ISSUE to IDLE is 34-35 cycles.
REQ-019 The timeout counter SHALL increment every cycle in ARM/WAIT; on reaching TIMEOUT it SHALL pulse to_exc and div_rst one cycle, leave HI/LO unchanged, and return to IDLE.
REQ-020 stall SHALL be 1 when busy and any of div_req, mfhi, mflo, mthi, mtlo is asserted; otherwise 0.
REQ-021 A div_req accepted in IDLE SHALL itself not stall; the next HI/LO access stalls until completion.
REQ-022 mthi/mtlo in IDLE SHALL write wr_data at the clock edge; both asserted together write both.
REQ-023 mfhi with mthi in the same IDLE cycle SHALL return the old HI (read before write); same for LO.
REQ-024 Priority in IDLE: div_req over mthi/mtlo; if both asserted, HI/LO are written by the divide only.
REQ-025 Quotient and remainder SHALL be passed unmodified (signed truncating semantics supplied by the divider).
REQ-026 div_dividend/div_divisor SHALL stay stable from ISSUE until return to IDLE.

Reset
REQ-027 rst SHALL asynchronously force IDLE, HI=0, LO=0, counter=0, div_dividend=div_divisor=0, div_start=0, dz_exc=to_exc=0.
REQ-028 div_rst SHALL equal 1 while rst is asserted, so a reset mid-divide also aborts the divider; no HI/LO update from the aborted divide.

Structure
REQ-029 A shared include SHALL hold the FSM state encodings (2 bits) and the TIMEOUT default; the divider and pipeline control use it.
REQ-030 The timeout counter SHALL be a separate sub-module hilo_timer (clear, enable, count, expired), width clog2(TIMEOUT+1).
REQ-031 The top level SHALL instantiate hilo_ctrl beside div, with div_start/div_end/div_rst wired directly.

Verification
REQ-032 div_req op_a=100, op_b=7 -> div_start one pulse; after completion LO=14, HI=2, busy low, no exceptions.
REQ-033 div_req op_a=-7, op_b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-034 div_req op_b=0 with HI=LO=0x55 -> dz_exc one cycle, div_start never asserted, HI/LO still 0x55.
REQ-035 mflo one cycle after div_req 100/7 -> stall high until completion, then rd_data=14 the cycle stall drops.
REQ-036 Divider model holds div_end low forever -> to_exc and div_rst pulse exactly TIMEOUT cycles after ISSUE; HI/LO unchanged; next divide succeeds.
REQ-037 rst asserted mid-WAIT -> immediate IDLE, HI=LO=0, busy=0; later div_end pulse does not write HI/LO.
